// File: rtl/conv_bcd_hh_bin_2dig.sv
// Two-digit BCD to binary converter for hour/minute/second fields.
// Reverse double-dabble over 7 iterations, with digit and range checks and a start/busy/done handshake.
module conv_bcd_hh_bin_2dig #(
    parameter int N   = 5,
    parameter int MAX = 23
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [3:0]   digit1,
    input  logic [3:0]   digit0,
    output logic         busy,
    output logic         done,
    output logic         error,
    output logic [N-1:0] bin_out
);

    typedef enum logic [2:0] {IDLE, CHECK, CONV, FIN, DONE} state_t;

    localparam logic [6:0] MAX7 = 7'(MAX);

    state_t      state;
    logic [14:0] sr;
    logic [2:0]  it;
    logic [14:0] shifted;
    logic [14:0] corrected;

    function automatic logic [3:0] fix_nibble(input logic [3:0] nib);
        return (nib >= 4'd8) ? nib - 4'd3 : nib;
    endfunction

    // One reverse double-dabble step: shift right, then undo the +3 on each BCD nibble.
    always_comb begin
        shifted   = {1'b0, sr[14:1]};
        corrected = {fix_nibble(shifted[14:11]), fix_nibble(shifted[10:7]), shifted[6:0]};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            sr      <= '0;
            it      <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            error   <= 1'b0;
            bin_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sr    <= {digit1, digit0, 7'b0};
                        busy  <= 1'b1;
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (sr[14:11] > 4'd9 || sr[10:7] > 4'd9) begin
                        error <= 1'b1;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        it    <= '0;
                        state <= CONV;
                    end
                end
                CONV: begin
                    sr <= corrected;
                    it <= it + 3'd1;
                    if (it == 3'd6) state <= FIN;
                end
                FIN: begin
                    // Compare on all 7 bits so values like 99 cannot alias into range.
                    if (sr[6:0] > MAX7) begin
                        error <= 1'b1;
                    end else begin
                        error   <= 1'b0;
                        bin_out <= sr[N-1:0];
                    end
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_bcd_hh_bin_2dig.sv
// Directed bench for conv_bcd_hh_bin_2dig: an hours instance (N=5, MAX=23) and a
// minutes instance (N=6, MAX=59) share the same stimulus; each vector selects which one is checked.
module tb_conv_bcd_hh_bin_2dig;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] digit1, digit0;
    logic       busy_a, done_a, error_a;
    logic [4:0] bin_a;
    logic       busy_b, done_b, error_b;
    logic [5:0] bin_b;

    always #5 clk = ~clk;

    conv_bcd_hh_bin_2dig #(.N(5), .MAX(23)) dut_a (
        .clk(clk), .reset(reset), .start(start), .digit1(digit1), .digit0(digit0),
        .busy(busy_a), .done(done_a), .error(error_a), .bin_out(bin_a)
    );

    conv_bcd_hh_bin_2dig #(.N(6), .MAX(59)) dut_b (
        .clk(clk), .reset(reset), .start(start), .digit1(digit1), .digit0(digit0),
        .busy(busy_b), .done(done_b), .error(error_b), .bin_out(bin_b)
    );

    typedef struct {
        logic [3:0] d1;
        logic [3:0] d0;
        int         sel;
        int         exp_bin;
        int         exp_err;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Launch one request and watch 14 falling edges; index 0 is the cycle right after the accepting edge.
    task automatic run(input logic [3:0] d1, input logic [3:0] d0, input int sel,
                       output int didx, output int ndone, output int nbusy,
                       output int rbin, output int rerr);
        @(negedge clk);
        digit1 = d1; digit0 = d0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        didx = -1; ndone = 0; nbusy = 0; rbin = -1; rerr = -1;
        for (int k = 0; k < 14; k++) begin
            if (k > 0) @(negedge clk);
            if ((sel == 0) ? busy_a : busy_b) nbusy++;
            if ((sel == 0) ? done_a : done_b) begin
                ndone++;
                didx = k;
                rbin = (sel == 0) ? int'(bin_a) : int'(bin_b);
                rerr = (sel == 0) ? int'(error_a) : int'(error_b);
            end
        end
    endtask

    initial begin
        int  didx, ndone, nbusy, rbin, rerr;
        int  first_idx, first_bin, second_idx, second_bin;
        bit  fast;
        vec_t v;

        // Sweep 00..23 on the hours instance, then out-of-range and bad-digit cases.
        for (int i = 0; i <= 23; i++) begin
            v.d1 = 4'(i / 10); v.d0 = 4'(i % 10); v.sel = 0; v.exp_bin = i; v.exp_err = 0;
            vecs.push_back(v);
        end
        v = '{4'd2, 4'd4, 0, 23, 1}; vecs.push_back(v);
        v = '{4'd9, 4'd9, 0, 23, 1}; vecs.push_back(v);
        v = '{4'd0, 4'hA, 0, 23, 1}; vecs.push_back(v);
        v = '{4'hF, 4'd0, 0, 23, 1}; vecs.push_back(v);
        v = '{4'd5, 4'd9, 1, 59, 0}; vecs.push_back(v);
        v = '{4'd6, 4'd0, 1, 59, 1}; vecs.push_back(v);
        v = '{4'd4, 4'd2, 1, 42, 0}; vecs.push_back(v);

        reset = 1'b0; start = 1'b0; digit1 = '0; digit0 = '0;
        repeat (2) @(negedge clk);
        check("reset busy", int'(busy_a), 0);
        check("reset done", int'(done_a), 0);
        check("reset error", int'(error_a), 0);
        check("reset bin", int'(bin_a), 0);
        reset = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            fast = (vecs[i].d1 > 4'd9) || (vecs[i].d0 > 4'd9);
            run(vecs[i].d1, vecs[i].d0, vecs[i].sel, didx, ndone, nbusy, rbin, rerr);
            check($sformatf("v%0d %0h%0h done count", i, vecs[i].d1, vecs[i].d0), ndone, 1);
            check($sformatf("v%0d %0h%0h done latency", i, vecs[i].d1, vecs[i].d0), didx, fast ? 1 : 9);
            check($sformatf("v%0d %0h%0h busy cycles", i, vecs[i].d1, vecs[i].d0), nbusy, fast ? 2 : 10);
            check($sformatf("v%0d %0h%0h bin", i, vecs[i].d1, vecs[i].d0), rbin, vecs[i].exp_bin);
            check($sformatf("v%0d %0h%0h error", i, vecs[i].d1, vecs[i].d0), rerr, vecs[i].exp_err);
        end

        // start held through busy with new digits: ignored while busy, re-accepted once IDLE.
        @(negedge clk);
        digit1 = 4'd1; digit0 = 4'd5; start = 1'b1;
        @(negedge clk);
        digit1 = 4'd0; digit0 = 4'd7;
        ndone = 0; first_idx = -1; first_bin = -1; second_idx = -1; second_bin = -1;
        for (int k = 0; k < 23; k++) begin
            if (k > 0) @(negedge clk);
            if (done_a) begin
                ndone++;
                if (first_idx < 0) begin first_idx = k; first_bin = int'(bin_a); end
                else begin second_idx = k; second_bin = int'(bin_a); end
            end
            if (k == 11) start = 1'b0;
        end
        check("hold dones", ndone, 2);
        check("hold first idx", first_idx, 9);
        check("hold first bin", first_bin, 15);
        check("hold second idx", second_idx, 20);
        check("hold second bin", second_bin, 7);

        // Asynchronous reset in the middle of a conversion of 19.
        @(negedge clk);
        digit1 = 4'd1; digit0 = 4'd9; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("abort busy", int'(busy_a), 0);
        check("abort done", int'(done_a), 0);
        check("abort error", int'(error_a), 0);
        check("abort bin", int'(bin_a), 0);
        ndone = 0;
        repeat (8) begin
            @(negedge clk);
            if (done_a) ndone++;
        end
        check("abort no done", ndone, 0);
        reset = 1'b1;
        run(4'd1, 4'd9, 0, didx, ndone, nbusy, rbin, rerr);
        check("after reset done count", ndone, 1);
        check("after reset latency", didx, 9);
        check("after reset bin", rbin, 19);
        check("after reset error", rerr, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
